hs_packer: RTL
==============

// Module: hs_packer
// PURPOSE
//   Width-up converter on the valid/ready stream path: packs RATIO consecutive
//   WIDTH-bit words into one WIDTH*RATIO-bit word for the wide consumer.
//   Sits directly downstream of the narrow input FIFO, ahead of the systolic
//   array row feeder. Supports early group close (last_i), lane mask and flush.
//   Two-slot design (accumulator + output register) keeps one word per cycle
//   while the consumer is ready.
// PARAMETERS
//   WIDTH  8  bits per input word
//   RATIO  4  input words per output word (>= 2)
// PORTS
//   clk_core    in   1            core clock; all state on rising edge
//   rst_core_n  in   1            asynchronous active-low reset
//   flush       in   1            synchronous discard of all buffered data
//   ready_o     out  1            upstream may transfer (registered state only)
//   valid_i     in   1            upstream word valid
//   in          in   WIDTH        upstream word
//   last_i      in   1            accepted word closes current group
//   ready_i     in   1            downstream accepts out this cycle
//   valid_o     out  1            out/keep_o/last_o valid
//   out         out  WIDTH*RATIO  packed word; lane k = out[k*WIDTH +: WIDTH]
//   keep_o      out  RATIO        lane k holds real data
//   last_o      out  1            group was closed by last_i
// BEHAVIOUR
//   - Reset (async): valid_o=0, out='0, keep_o='0, last_o=0, lane count=0,
//     acc_done=0, so ready_o=1. Same end state on flush (sync).
//   - Accept = valid_i & ready_o; drain = valid_o & ready_i.
//   - Lane order: first accepted word of a group -> lane 0 (LSBs), upward.
//     cnt (clog2(RATIO)+1 bits) counts lanes filled in accumulator.
//   - Group completes on accept when cnt==RATIO-1 or last_i=1.
//     Unfilled lanes are '0, keep bits 0; last_o = last_i of closing word.
//   - ready_o = ~acc_done. No combinational path ready_i -> ready_o.
//   - On completing accept at cycle t:
//     * out slot free (~valid_o) or drain at t -> at t+1: out/keep_o/last_o
//       loaded, valid_o=1, cnt=0. Latency completing word -> valid_o: 1 cycle.
//     * otherwise -> acc_done=1, cnt holds; ready_o=0 from t+1.
//   - acc_done=1 and drain at t -> at t+1 acc moves to out, valid_o stays 1,
//     acc_done=0, cnt=0, accumulator cleared.
//   - Drain with nothing pending -> valid_o=0 at t+1; out holds last value.
//   - valid_o & ~ready_i: out, keep_o, last_o, valid_o held stable.
//   - Drain and completing accept in same cycle: new word loads out at t+1,
//     valid_o stays 1 (full throughput, one output per RATIO inputs).
//   - last_i with valid_i=0 or ready_o=0 is ignored.
//   - flush wins over every same-cycle event; word accepted in flush cycle
//     is discarded; ready_o=1 the next cycle.
//   - Reset mid-group: partial data lost, no output produced.
// TESTING
//   - Reset, WIDTH=8 RATIO=4, feed 01,02,03,04 back-to-back, ready_i=1 ->
//     out=32'h04030201, keep_o=4'hF, last_o=0, valid_o one cycle after 04.
//   - Feed 0A,0B with last_i on 0B -> out=32'h00000B0A, keep_o=4'h3, last_o=1;
//     next group restarts at lane 0.
//   - ready_i=0, feed 8 words -> first output held stable, second packed,
//     ready_o=0 after 8th; raise ready_i -> second out next cycle, ready_o=1.
//   - Continuous valid_i and ready_i over 64 words -> 16 outputs, no bubble
//     on ready_o, no data loss or reorder (scoreboard).
//   - Flush with 3 lanes filled and valid_o=1 -> next cycle valid_o=0,
//     ready_o=1; next 4 words yield fresh word with keep_o=4'hF.
//   - Assert rst_core_n low mid-group, async -> valid_o=0, keep_o=0
//     immediately, no clock edge needed.

Source files
------------

// File: rtl/hs_packer.sv
// Width-up stream packer: gathers RATIO narrow words into one wide word with
// lane keep mask and early close; accumulator plus output register sustain one word per cycle.
module hs_packer #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned RATIO = 4
) (
  input  logic                     clk_core,
  input  logic                     rst_core_n,
  input  logic                     flush,
  output logic                     ready_o,
  input  logic                     valid_i,
  input  logic [WIDTH-1:0]         in,
  input  logic                     last_i,
  input  logic                     ready_i,
  output logic                     valid_o,
  output logic [WIDTH*RATIO-1:0]   out,
  output logic [RATIO-1:0]         keep_o,
  output logic                     last_o
);

  localparam int unsigned OW = WIDTH * RATIO;
  localparam int unsigned CW = $clog2(RATIO) + 1;

  logic [OW-1:0]    acc_data,  acc_data_nxt;
  logic [RATIO-1:0] acc_keep,  acc_keep_nxt;
  logic             acc_last,  acc_last_nxt;
  logic             acc_done,  acc_done_nxt;
  logic [CW-1:0]    cnt,       cnt_nxt;
  logic             valid_nxt;
  logic [OW-1:0]    out_nxt;
  logic [RATIO-1:0] keep_nxt;
  logic             last_nxt;
  logic             ready_nxt;

  logic             accept_c;
  logic             drain_c;
  logic             closing_c;
  logic [OW-1:0]    merged_data_c;
  logic [RATIO-1:0] merged_keep_c;

  // Accumulator contents with the incoming word dropped into lane cnt.
  always_comb begin
    merged_data_c = acc_data;
    merged_keep_c = acc_keep;
    for (int k = 0; k < int'(RATIO); k++) begin
      if (CW'(k) == cnt) begin
        merged_data_c[k*WIDTH +: WIDTH] = in;
        merged_keep_c[k]                = 1'b1;
      end
    end
  end

  assign accept_c  = valid_i & ready_o;
  assign drain_c   = valid_o & ready_i;
  assign closing_c = accept_c & ((cnt == CW'(RATIO - 1)) | last_i);

  // Next-state: flush beats everything; a parked group moves out before new data is taken.
  always_comb begin
    acc_data_nxt = acc_data;
    acc_keep_nxt = acc_keep;
    acc_last_nxt = acc_last;
    acc_done_nxt = acc_done;
    cnt_nxt      = cnt;
    valid_nxt    = valid_o;
    out_nxt      = out;
    keep_nxt     = keep_o;
    last_nxt     = last_o;

    if (flush) begin
      acc_data_nxt = '0;
      acc_keep_nxt = '0;
      acc_last_nxt = 1'b0;
      acc_done_nxt = 1'b0;
      cnt_nxt      = '0;
      valid_nxt    = 1'b0;
      out_nxt      = '0;
      keep_nxt     = '0;
      last_nxt     = 1'b0;
    end else if (acc_done) begin
      if (drain_c) begin
        out_nxt      = acc_data;
        keep_nxt     = acc_keep;
        last_nxt     = acc_last;
        valid_nxt    = 1'b1;
        acc_data_nxt = '0;
        acc_keep_nxt = '0;
        acc_last_nxt = 1'b0;
        acc_done_nxt = 1'b0;
        cnt_nxt      = '0;
      end
    end else if (closing_c) begin
      if (!valid_o || drain_c) begin
        out_nxt      = merged_data_c;
        keep_nxt     = merged_keep_c;
        last_nxt     = last_i;
        valid_nxt    = 1'b1;
        acc_data_nxt = '0;
        acc_keep_nxt = '0;
        acc_last_nxt = 1'b0;
        cnt_nxt      = '0;
      end else begin
        // Output slot busy: park the completed group and stall upstream.
        acc_data_nxt = merged_data_c;
        acc_keep_nxt = merged_keep_c;
        acc_last_nxt = last_i;
        acc_done_nxt = 1'b1;
      end
    end else begin
      if (accept_c) begin
        acc_data_nxt = merged_data_c;
        acc_keep_nxt = merged_keep_c;
        cnt_nxt      = cnt + CW'(1);
      end
      if (drain_c) begin
        valid_nxt = 1'b0;
      end
    end

    ready_nxt = ~acc_done_nxt;
  end

  always_ff @(posedge clk_core or negedge rst_core_n) begin
    if (!rst_core_n) begin
      acc_data <= '0;
      acc_keep <= '0;
      acc_last <= 1'b0;
      acc_done <= 1'b0;
      cnt      <= '0;
      valid_o  <= 1'b0;
      out      <= '0;
      keep_o   <= '0;
      last_o   <= 1'b0;
      ready_o  <= 1'b1;
    end else begin
      acc_data <= acc_data_nxt;
      acc_keep <= acc_keep_nxt;
      acc_last <= acc_last_nxt;
      acc_done <= acc_done_nxt;
      cnt      <= cnt_nxt;
      valid_o  <= valid_nxt;
      out      <= out_nxt;
      keep_o   <= keep_nxt;
      last_o   <= last_nxt;
      ready_o  <= ready_nxt;
    end
  end

endmodule
